traffic_phase_ctrl: RTL



---
 rtl/traffic_phase_ctrl_if.sv | 21 ++
 rtl/traffic_phase_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl_if.sv
// Board-side bundle for the intersection controller: push-button and
// night switch in; lamp pins, display value, phase code and tick out.
interface traffic_phase_ctrl_if;
    logic        ped_req;
    logic        night_mode;
    logic [2:0]  ns_lamp;
    logic [2:0]  ew_lamp;
    logic [13:0] dat;
    logic [2:0]  phase;
    logic        tick;

    modport master (
        output ped_req, night_mode,
        input  ns_lamp, ew_lamp, dat, phase, tick
    );

    modport slave (
        input  ped_req, night_mode,
        output ns_lamp, ew_lamp, dat, phase, tick
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-direction traffic phase sequencer with all-red clearance,
// pedestrian shortening, night flashing and a countdown display value.
// Ports: clk, rst_n (async active-low), bus (slave): ped_req, night_mode
// in; ns_lamp/ew_lamp {r,y,g}, dat (ns_sec*100+ew_sec), phase, tick out.
module traffic_phase_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int GREEN_T  = 30,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int PED_MIN  = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    traffic_phase_ctrl_if.slave bus
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [5:0] G6 = 6'(GREEN_T);
    localparam logic [5:0] Y6 = 6'(YELLOW_T);
    localparam logic [5:0] A6 = 6'(ALLRED_T);
    localparam logic [5:0] P6 = 6'(PED_MIN);

    localparam logic [7:0] ADD_A   = 8'(ALLRED_T);
    localparam logic [7:0] ADD_YA  = 8'(YELLOW_T + ALLRED_T);
    localparam logic [7:0] ADD_GYA = 8'(GREEN_T + YELLOW_T + ALLRED_T);

    typedef enum logic [2:0] {
        ALLRED_A = 3'd0,
        NS_G     = 3'd1,
        NS_Y     = 3'd2,
        ALLRED_B = 3'd3,
        EW_G     = 3'd4,
        EW_Y     = 3'd5,
        NIGHT    = 3'd6
    } state_t;

    logic [CW-1:0] div_q;
    logic          tick_w;

    state_t     state_q, state_d, succ;
    logic [5:0] rem_q, rem_d, succ_dur;
    logic       ped_q, ped_d;
    logic       blink_q, blink_d;
    logic       honor;

    logic [2:0]  ns_lamp_d, ew_lamp_d;
    logic [7:0]  ns_raw, ew_raw;
    logic [6:0]  ns_sec, ew_sec;
    logic [13:0] dat_d;

    logic [2:0]  ns_lamp_q, ew_lamp_q, phase_q;
    logic [13:0] dat_q;

    // Free-running 1 s divider; phase changes never reload it.
    assign tick_w = (div_q == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick_w) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ALLRED_A;
            rem_q   <= A6;
            ped_q   <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ped_q   <= ped_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        succ     = ALLRED_A;
        succ_dur = A6;
        unique case (state_q)
            ALLRED_A: begin succ = NS_G;     succ_dur = G6; end
            NS_G:     begin succ = NS_Y;     succ_dur = Y6; end
            NS_Y:     begin succ = ALLRED_B; succ_dur = A6; end
            ALLRED_B: begin succ = EW_G;     succ_dur = G6; end
            EW_G:     begin succ = EW_Y;     succ_dur = Y6; end
            EW_Y:     begin succ = ALLRED_A; succ_dur = A6; end
            default:  begin succ = ALLRED_A; succ_dur = A6; end
        endcase
    end

    assign honor = ped_q && (state_q == NS_G || state_q == EW_G);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        blink_d = blink_q;
        ped_d   = ped_q | bus.ped_req;
        if (state_q == NIGHT) begin
            ped_d = 1'b0;
        end
        if (tick_w) begin
            if (state_q == NIGHT) begin
                if (!bus.night_mode) begin
                    state_d = ALLRED_A;
                    rem_d   = A6;
                end else begin
                    blink_d = ~blink_q;
                end
            end else if (bus.night_mode) begin
                state_d = NIGHT;
                ped_d   = 1'b0;
                blink_d = 1'b1;
            end else begin
                if (rem_q == 6'd1) begin
                    state_d = succ;
                    rem_d   = succ_dur;
                end else if (honor && rem_q > P6) begin
                    rem_d = P6;
                end else begin
                    rem_d = rem_q - 6'd1;
                end
                // A request landing on the clearing tick re-arms the latch.
                if (honor) begin
                    ped_d = bus.ped_req;
                end
            end
        end
    end

    // The red direction counts down to its own next green.
    always_comb begin
        ns_lamp_d = 3'b100;
        ew_lamp_d = 3'b100;
        ns_raw    = '0;
        ew_raw    = '0;
        unique case (state_q)
            ALLRED_A: begin
                ns_raw = {2'b00, rem_q};
                ew_raw = {2'b00, rem_q} + ADD_GYA;
            end
            NS_G: begin
                ns_lamp_d = 3'b001;
                ns_raw    = {2'b00, rem_q};
                ew_raw    = {2'b00, rem_q} + ADD_YA;
            end
            NS_Y: begin
                ns_lamp_d = 3'b010;
                ns_raw    = {2'b00, rem_q};
                ew_raw    = {2'b00, rem_q} + ADD_A;
            end
            ALLRED_B: begin
                ew_raw = {2'b00, rem_q};
                ns_raw = {2'b00, rem_q} + ADD_GYA;
            end
            EW_G: begin
                ew_lamp_d = 3'b001;
                ew_raw    = {2'b00, rem_q};
                ns_raw    = {2'b00, rem_q} + ADD_YA;
            end
            EW_Y: begin
                ew_lamp_d = 3'b010;
                ew_raw    = {2'b00, rem_q};
                ns_raw    = {2'b00, rem_q} + ADD_A;
            end
            NIGHT: begin
                ns_lamp_d = {1'b0, blink_q, 1'b0};
                ew_lamp_d = {1'b0, blink_q, 1'b0};
            end
            default: begin
                ns_lamp_d = 3'b100;
                ew_lamp_d = 3'b100;
            end
        endcase
    end

    assign ns_sec = (ns_raw > 8'd99) ? 7'd99 : ns_raw[6:0];
    assign ew_sec = (ew_raw > 8'd99) ? 7'd99 : ew_raw[6:0];
    assign dat_d  = {7'd0, ns_sec} * 14'd100 + {7'd0, ew_sec};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ns_lamp_q <= 3'b100;
            ew_lamp_q <= 3'b100;
            dat_q     <= '0;
            phase_q   <= '0;
        end else begin
            ns_lamp_q <= ns_lamp_d;
            ew_lamp_q <= ew_lamp_d;
            dat_q     <= dat_d;
            phase_q   <= state_q;
        end
    end

    assign bus.ns_lamp = ns_lamp_q;
    assign bus.ew_lamp = ew_lamp_q;
    assign bus.dat     = dat_q;
    assign bus.phase   = phase_q;
    assign bus.tick    = tick_w;

endmodule
